// File: rtl/round_ctrl.sv
// Round sequencer for the maze-walk game: countdown, timed play, step-pulse
// generation and a saturating win tally around the character walker.
module round_ctrl #(
  parameter int unsigned SEC_DIV   = 100_000_000,
  parameter int unsigned CD_START  = 3,
  parameter int unsigned PLAY_TIME = 60,
  parameter int unsigned MOVE_DIV  = 10_000_000
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       start,
  input  logic       btnD_in,
  input  logic       btnR_in,
  input  logic       win,
  output logic       walk_clr,
  output logic [2:0] cd_cnt,
  output logic       btnD,
  output logic       btnR,
  output logic [1:0] phase,
  output logic [6:0] time_left,
  output logic       result_win,
  output logic [3:0] win_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    PLAY  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned SEC_W = $clog2(SEC_DIV);
  localparam int unsigned MV_W  = $clog2(MOVE_DIV);
  localparam logic [SEC_W-1:0] SEC_LAST  = SEC_W'(SEC_DIV - 1);
  localparam logic [MV_W-1:0]  MV_LAST   = MV_W'(MOVE_DIV - 1);
  localparam logic [2:0]       CD_LOAD   = 3'(CD_START);
  localparam logic [6:0]       TIME_LOAD = 7'(PLAY_TIME);

  state_t           r_state;
  logic             r_start_s1, r_start_s2, r_start_s3;
  logic             r_dn_s1, r_dn_s2, r_rt_s1, r_rt_s2;
  logic [SEC_W-1:0] r_sec_q;
  logic [MV_W-1:0]  r_mv_q;
  logic             r_walk_clr, r_btnD, r_btnR, r_result_win;
  logic [2:0]       r_cd_cnt;
  logic [6:0]       r_time_left;
  logic [3:0]       r_win_cnt;

  logic w_start_edge, w_sec_tick, w_enter_count, w_enter_play;
  logic w_leave_play, w_mv_run;

  // NOTE: every clocked block uses non-blocking assignments so all flops
  // sample pre-edge values and the synchroniser chains really delay.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_start_s1 <= 1'b0;
      r_start_s2 <= 1'b0;
      r_start_s3 <= 1'b0;
      r_dn_s1    <= 1'b0;
      r_dn_s2    <= 1'b0;
      r_rt_s1    <= 1'b0;
      r_rt_s2    <= 1'b0;
    end else begin
      r_start_s1 <= start;
      r_start_s2 <= r_start_s1;
      r_start_s3 <= r_start_s2;
      r_dn_s1    <= btnD_in;
      r_dn_s2    <= r_dn_s1;
      r_rt_s1    <= btnR_in;
      r_rt_s2    <= r_rt_s1;
    end
  end

  assign w_start_edge  = r_start_s2 && !r_start_s3;
  assign w_sec_tick    = (r_sec_q == SEC_LAST);
  assign w_enter_count = w_start_edge && (r_state == IDLE || r_state == DONE);
  assign w_enter_play  = (r_state == COUNT) && w_sec_tick && (r_cd_cnt == 3'd1);
  assign w_leave_play  = (r_state == PLAY) &&
                         (win || (w_sec_tick && r_time_left == 7'd1));
  // The step counter stops on the edge that leaves PLAY, so no pulse
  // ever appears alongside phase=DONE.
  assign w_mv_run      = (r_state == PLAY) && (r_dn_s2 || r_rt_s2) && !w_leave_play;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_sec_q <= '0;
    end else if (w_enter_count || w_enter_play || w_sec_tick) begin
      r_sec_q <= '0;
    end else begin
      r_sec_q <= r_sec_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_mv_q <= '0;
      r_btnD <= 1'b0;
      r_btnR <= 1'b0;
    end else begin
      r_btnD <= w_mv_run && (r_mv_q == '0) && r_dn_s2;
      r_btnR <= w_mv_run && (r_mv_q == '0) && r_rt_s2;
      if (!w_mv_run || r_mv_q == MV_LAST) begin
        r_mv_q <= '0;
      end else begin
        r_mv_q <= r_mv_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state      <= IDLE;
      r_walk_clr   <= 1'b1;
      r_cd_cnt     <= '0;
      r_time_left  <= '0;
      r_result_win <= 1'b0;
      r_win_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_walk_clr <= 1'b1;
          r_cd_cnt   <= '0;
          if (w_start_edge) begin
            r_state  <= COUNT;
            r_cd_cnt <= CD_LOAD;
          end
        end
        COUNT: begin
          r_walk_clr <= 1'b0;
          if (w_sec_tick) begin
            if (r_cd_cnt > 3'd1) begin
              r_cd_cnt <= r_cd_cnt - 3'd1;
            end else begin
              r_cd_cnt    <= '0;
              r_time_left <= TIME_LOAD;
              r_state     <= PLAY;
            end
          end
        end
        PLAY: begin
          r_walk_clr <= 1'b0;
          if (win) begin
            r_state      <= DONE;
            r_result_win <= 1'b1;
            if (r_win_cnt != 4'hF) r_win_cnt <= r_win_cnt + 4'd1;
          end else if (w_sec_tick) begin
            if (r_time_left > 7'd1) begin
              r_time_left <= r_time_left - 7'd1;
            end else begin
              r_time_left  <= '0;
              r_result_win <= 1'b0;
              r_state      <= DONE;
            end
          end
        end
        DONE: begin
          r_walk_clr <= 1'b0;
          r_cd_cnt   <= '0;
          if (w_start_edge) begin
            r_state    <= COUNT;
            r_cd_cnt   <= CD_LOAD;
            r_walk_clr <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign phase      = r_state;
  assign walk_clr   = r_walk_clr;
  assign cd_cnt     = r_cd_cnt;
  assign btnD       = r_btnD;
  assign btnR       = r_btnR;
  assign time_left  = r_time_left;
  assign result_win = r_result_win;
  assign win_cnt    = r_win_cnt;

endmodule

// File: tb/tb_round_ctrl.sv
// Directed bench for round_ctrl: countdown, step pulses, timeout, win,
// tally saturation and asynchronous reset in the middle of a round.
module tb_round_ctrl;

  logic       clk = 1'b0;
  logic       clr_n, start, btnD_in, btnR_in, win;
  logic       walk_clr, btnD, btnR, result_win;
  logic [2:0] cd_cnt;
  logic [1:0] phase;
  logic [6:0] time_left;
  logic [3:0] win_cnt;

  int n_checks = 0;
  int n_errors = 0;

  round_ctrl #(
    .SEC_DIV  (4),
    .CD_START (3),
    .PLAY_TIME(5),
    .MOVE_DIV (3)
  ) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .start     (start),
    .btnD_in   (btnD_in),
    .btnR_in   (btnR_in),
    .win       (win),
    .walk_clr  (walk_clr),
    .cd_cnt    (cd_cnt),
    .btnD      (btnD),
    .btnR      (btnR),
    .phase     (phase),
    .time_left (time_left),
    .result_win(result_win),
    .win_cnt   (win_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_phase"},  32'(phase), 0);
    check({tag, "_wclr"},   32'(walk_clr), 1);
    check({tag, "_cd"},     32'(cd_cnt), 0);
    check({tag, "_btns"},   32'({btnD, btnR}), 0);
    check({tag, "_time"},   32'(time_left), 0);
    check({tag, "_result"}, 32'(result_win), 0);
    check({tag, "_wcnt"},   32'(win_cnt), 0);
  endtask

  // Pulse start from IDLE/DONE and follow the round into PLAY.
  task automatic start_round();
    win   = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check("rs_phase_count", 32'(phase), 1);
    check("rs_cd_load", 32'(cd_cnt), 3);
    check("rs_wclr_hi", 32'(walk_clr), 1);
    step();
    check("rs_wclr_lo", 32'(walk_clr), 0);
    repeat (11) step();
    check("rs_phase_play", 32'(phase), 2);
    check("rs_cd_zero", 32'(cd_cnt), 0);
    check("rs_time_load", 32'(time_left), 5);
  endtask

  initial begin
    int exp_wc;
    clr_n   = 1'b0;
    start   = 1'b0;
    btnD_in = 1'b0;
    btnR_in = 1'b0;
    win     = 1'b0;
    step();
    step();
    check_reset_values("rst0");
    clr_n = 1'b1;
    step();

    // Round 1: detailed countdown.
    start = 1'b1;
    step();
    check("idle_e1_phase", 32'(phase), 0);
    check("idle_e1_wclr", 32'(walk_clr), 1);
    start = 1'b0;
    step();
    check("idle_e2_phase", 32'(phase), 0);
    step();
    check("cnt_e3_phase", 32'(phase), 1);
    check("cnt_e3_cd", 32'(cd_cnt), 3);
    check("cnt_e3_wclr", 32'(walk_clr), 1);
    for (int k = 1; k <= 12; k++) begin
      step();
      check("cd_run", 32'(cd_cnt), (k < 4) ? 3 : (k < 8) ? 2 : (k < 12) ? 1 : 0);
      check("cd_phase", 32'(phase), (k < 12) ? 1 : 2);
      check("cd_wclr", 32'(walk_clr), 0);
    end
    check("play_time_load", 32'(time_left), 5);

    // Held right button for 10 cycles.
    btnR_in = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k == 10) btnR_in = 1'b0;
      check("hold_r_btnR", 32'(btnR), (k % 3 == 0 && k <= 12) ? 1 : 0);
      check("hold_r_btnD", 32'(btnD), 0);
    end
    check("r1_time2", 32'(time_left), 2);
    check("r1_phase_play", 32'(phase), 2);

    // Win at time_left=2.
    win = 1'b1;
    step();
    check("win_phase", 32'(phase), 3);
    check("win_result", 32'(result_win), 1);
    check("win_cnt1", 32'(win_cnt), 1);
    check("win_time_held", 32'(time_left), 2);
    step();
    check("done_time_held", 32'(time_left), 2);
    check("done_cd", 32'(cd_cnt), 0);

    // Round 2: both buttons held, then timeout.
    start_round();
    btnD_in = 1'b1;
    btnR_in = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 7) begin
        btnD_in = 1'b0;
        btnR_in = 1'b0;
      end
      if (k <= 10) begin
        check("both_btnD", 32'(btnD), (k % 3 == 0) ? 1 : 0);
        check("both_btnR", 32'(btnR), (k % 3 == 0) ? 1 : 0);
      end
      check("to_time", 32'(time_left), 5 - k / 4);
      check("to_phase", 32'(phase), (k < 20) ? 2 : 3);
    end
    check("to_result", 32'(result_win), 0);
    check("to_wcnt", 32'(win_cnt), 1);
    btnD_in = 1'b1;
    btnR_in = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      check("done_no_pulse", 32'({btnD, btnR}), 0);
      check("done_phase", 32'(phase), 3);
    end
    btnD_in = 1'b0;
    btnR_in = 1'b0;
    check("done_time0", 32'(time_left), 0);

    // Round 3: win on the final tick.
    start_round();
    repeat (19) step();
    check("ft_time1", 32'(time_left), 1);
    check("ft_phase_play", 32'(phase), 2);
    win = 1'b1;
    step();
    check("ft_phase", 32'(phase), 3);
    check("ft_time", 32'(time_left), 1);
    check("ft_result", 32'(result_win), 1);
    check("ft_wcnt", 32'(win_cnt), 2);

    // Saturation via replay from DONE.
    exp_wc = 2;
    for (int r = 0; r < 15; r++) begin
      start_round();
      step();
      step();
      win = 1'b1;
      step();
      exp_wc = (exp_wc < 15) ? exp_wc + 1 : 15;
      check("sat_phase", 32'(phase), 3);
      check("sat_result", 32'(result_win), 1);
      check("sat_wcnt", 32'(win_cnt), 32'(exp_wc));
    end
    check("sat_final", 32'(win_cnt), 15);

    // Asynchronous reset in the middle of PLAY, during a step pulse.
    start_round();
    btnR_in = 1'b1;
    repeat (3) step();
    check("pre_rst_pulse", 32'(btnR), 1);
    check("pre_rst_phase", 32'(phase), 2);
    #2;
    clr_n = 1'b0;
    #1;
    check_reset_values("rst_play");
    btnR_in = 1'b0;
    step();
    clr_n = 1'b1;
    step();
    check("post_rst_phase", 32'(phase), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/round_ctrl.md
# round_ctrl

Round sequencer for the maze-walk game. It owns the character walker's control inputs: the clear, the start countdown (`cd_cnt`) and the rate-limited step pulses (`btnD`/`btnR`). It watches the walker's `win` flag, enforces a play-time limit and keeps a saturating win tally. It sits between the raw board buttons and the walker, and feeds the display logic with countdown, time and result.

## Interface
- `SEC_DIV`, default 100_000_000: clock cycles per game second (≥2).
- `CD_START`, default 3: first countdown value (1..7).
- `PLAY_TIME`, default 60: play-time seconds per round (1..127).
- `MOVE_DIV`, default 10_000_000: cycles between repeated step pulses while a button is held (≥2).
- `clk` in 1: system clock. All logic is on its rising edge.
- `clr_n` in 1: asynchronous, active-low reset.
- `start` in 1: raw start button, level. Synchronised internally; acts on its rising edge.
- `btnD_in` in 1: raw down button, level, held.
- `btnR_in` in 1: raw right button, level, held.
- `win` in 1: walker has reached the goal (sticky in the walker until it is cleared).
- `walk_clr` out 1: clear to the walker, active-high.
- `cd_cnt` out 3: countdown to the walker; nonzero holds the walker at its start position.
- `btnD` out 1: one-cycle down-step pulse to the walker.
- `btnR` out 1: one-cycle right-step pulse to the walker.
- `phase` out 2: FSM state; IDLE=0, COUNT=1, PLAY=2, DONE=3.
- `time_left` out 7: remaining play seconds.
- `result_win` out 1: the last round ended in a win.
- `win_cnt` out 4: rounds won, saturating at 15.

## Operation
- **Synchronisers.** `start`, `btnD_in` and `btnR_in` each pass through 2 flip-flops.
  - Start edge = synced start high AND a third (previous) flop low.
- **Second counter** `sec_q`.
  - Cleared on entry to COUNT and on entry to PLAY.
  - Otherwise increments; wraps from SEC_DIV-1 to 0.
  - `sec_tick` = (`sec_q` == SEC_DIV-1).
- **IDLE.**
  - `walk_clr`=1, `cd_cnt`=0, steps gated off.
  - Start edge → COUNT, load `cd_cnt`=CD_START.
- **COUNT.**
  - `walk_clr`=1 in the first COUNT cycle only, which clears the walker's sticky `win`.
  - On `sec_tick`: if `cd_cnt`>1, decrement it.
  - If `cd_cnt`==1: set `cd_cnt`=0, load `time_left`=PLAY_TIME, go to PLAY.
  - Start edges are ignored.
- **PLAY.**
  - Step generator enabled.
  - `win`=1 → DONE, `result_win`=1, `win_cnt` incremented unless it is 15.
  - On `sec_tick` with `time_left`>1: decrement `time_left`.
  - On `sec_tick` with `time_left`==1: set `time_left`=0, `result_win`=0, go to DONE.
  - If `win` and the final tick land in the same cycle, `win` has priority and `time_left` stays 1.
- **DONE.**
  - Steps gated off; `time_left`, `result_win` and `cd_cnt`=0 are held.
  - Start edge → COUNT with `cd_cnt`=CD_START. `result_win` is held until the next round ends.
- **Step generator** (one shared counter `mv_q`).
  - Counts only while in PLAY and at least one synced button is high; otherwise `mv_q`=0.
  - When `mv_q`==0 and counting: pulse `btnD`/`btnR` for each held button; both may pulse together.
  - `mv_q` wraps from MOVE_DIV-1 to 0, so a held button gives pulses every MOVE_DIV cycles.
  - Leaving PLAY clears `mv_q`; no pulse is ever emitted outside PLAY.
- **Reset** (`clr_n` low, asynchronous) returns everything to reset values from any state, mid-countdown or mid-play included.

## Timing
- **Reset values:**
  - `phase`=IDLE, `walk_clr`=1, `cd_cnt`=0
  - `btnD`=`btnR`=0
  - `time_left`=0, `result_win`=0, `win_cnt`=0
  - all synchronisers, `sec_q` and `mv_q` = 0
- **Start latency.** Raw `start` rising before clock edge 1 gives `phase`=COUNT after edge 3.
- **Countdown.**
  - Each `cd_cnt` value lasts exactly SEC_DIV cycles.
  - PLAY is entered CD_START·SEC_DIV cycles after COUNT entry.
- **Step latency.** Raw button high before edge 1 in PLAY gives its step pulse high after edge 3, lasting 1 cycle. The next pulse follows MOVE_DIV cycles later.
- **Win response.** `win` high at edge n gives `phase`=DONE after edge n; it is registered, not combinational.
- **Registered outputs.** `walk_clr`, `btnD` and `btnR` are registered; `cd_cnt` changes on the same edge as `phase`.

## Test plan
Bench parameters: SEC_DIV=4, CD_START=3, PLAY_TIME=5, MOVE_DIV=3.

- **Reset mid-PLAY:** drop `clr_n` → all outputs at reset values immediately, without waiting for a clock; `win_cnt`=0.
- **Countdown:** start pulse → COUNT after 3 edges; `cd_cnt` runs 3,2,1 for 4 cycles each; `walk_clr` high for 1 COUNT cycle; `cd_cnt`=0 and PLAY after 12 cycles, `time_left`=5.
- **Held button:** hold `btnR_in` in PLAY for 10 cycles → `btnR` pulses at offsets 3, 6, 9, 12 from assertion; `btnD` stays 0; both held → `btnD` and `btnR` pulse in the same cycles.
- **Timeout:** no win → `time_left` 5→0 over 20 cycles; DONE, `result_win`=0, `win_cnt` unchanged; buttons give no pulses.
- **Win:** assert `win` at `time_left`=2 → DONE next edge, `result_win`=1, `win_cnt`=1. `win` asserted on the final tick → win result with `time_left`=1.
- **Saturation and replay:** 16 winning rounds via start from DONE → `win_cnt` holds at 15; each new round re-enters COUNT with `cd_cnt`=3 and a 1-cycle `walk_clr`.
